// File: rtl/cmos_rgb565_capture_pkg.sv
// rtl/cmos_rgb565_capture_pkg.sv - shared constants for the DVP RGB565 capture front end
package cmos_rgb565_capture_pkg;

  localparam int R_MSB = 15;
  localparam int G_MSB = 10;
  localparam int B_MSB = 4;

  localparam int PIX_CNT_W = 12;

  localparam logic BYTE0 = 1'b0;
  localparam logic BYTE1 = 1'b1;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb888_t;

endpackage

// File: rtl/cmos_rgb565_capture_rgb565_to_rgb888.sv
// rtl/cmos_rgb565_capture_rgb565_to_rgb888.sv - combinational RGB565 to RGB888 bit-replication expander
module rgb565_to_rgb888
  import cmos_rgb565_capture_pkg::*;
(
  input  logic [15:0] i_rgb565,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue
);

  logic [4:0] w_r5;
  logic [5:0] w_g6;
  logic [4:0] w_b5;

  assign w_r5 = i_rgb565[R_MSB -: 5];
  assign w_g6 = i_rgb565[G_MSB -: 6];
  assign w_b5 = i_rgb565[B_MSB -: 5];

  // Replicating the MSBs into the LSBs maps full-scale codes to 0xFF exactly.
  assign o_red   = {w_r5, w_r5[4:2]};
  assign o_green = {w_g6, w_g6[5:4]};
  assign o_blue  = {w_b5, w_b5[4:2]};

endmodule

// File: rtl/cmos_rgb565_capture.sv
// rtl/cmos_rgb565_capture.sv - DVP byte stream to gated RGB888 video bus with start-up frame skip
module cmos_rgb565_capture
  import cmos_rgb565_capture_pkg::*;
#(
  parameter int FRAME_SKIP    = 10,
  parameter int H_PIXELS      = 640,
  parameter int HI_BYTE_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmos_vsync,
  input  logic       cmos_href,
  input  logic       cmos_de,
  input  logic [7:0] cmos_data,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_red,
  output logic [7:0] post_img_green,
  output logic [7:0] post_img_blue,
  output logic       frame_valid,
  output logic       byte_err,
  output logic       line_err
);

  localparam int FCW = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;
  localparam logic [FCW-1:0]       SKIP_TGT = FCW'(FRAME_SKIP);
  localparam logic [PIX_CNT_W-1:0] H_TGT    = PIX_CNT_W'(H_PIXELS);
  localparam logic [PIX_CNT_W-1:0] PIX_MAX  = '1;

  logic                 r_vsync_d;
  logic                 r_href_d;
  logic [FCW-1:0]       r_frame_cnt;
  logic                 r_frame_valid;
  logic                 r_state;
  logic [7:0]           r_byte;
  logic [PIX_CNT_W-1:0] r_pix_cnt;
  logic                 r_vsync_o;
  logic                 r_href_o;
  logic                 r_clken;
  logic [7:0]           r_red;
  logic [7:0]           r_green;
  logic [7:0]           r_blue;
  logic                 r_byte_err;
  logic                 r_line_err;

  logic        w_vsync_rise;
  logic        w_href_rise;
  logic        w_href_fall;
  logic        w_strobe;
  logic        w_valid_next;
  logic        w_pix_done;
  logic [15:0] w_word;
  logic [7:0]  w_red;
  logic [7:0]  w_green;
  logic [7:0]  w_blue;

  assign w_vsync_rise = cmos_vsync & ~r_vsync_d;
  assign w_href_rise  = cmos_href & ~r_href_d;
  assign w_href_fall  = ~cmos_href & r_href_d;
  assign w_strobe     = cmos_de & cmos_href;

  // Gate opens on the enabling vsync edge itself so that frame's vsync is forwarded.
  assign w_valid_next = r_frame_valid | (w_vsync_rise & (r_frame_cnt == SKIP_TGT));

  // A strobe coincident with href rising always starts a new pair.
  assign w_pix_done = w_strobe & (r_state == BYTE1) & ~w_href_rise;
  assign w_word     = (HI_BYTE_FIRST != 0) ? {r_byte, cmos_data} : {cmos_data, r_byte};

  rgb565_to_rgb888 u_expand (
    .i_rgb565 (w_word),
    .o_red    (w_red),
    .o_green  (w_green),
    .o_blue   (w_blue)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_d     <= cmos_vsync;
      r_href_d      <= cmos_href;
      r_frame_cnt   <= '0;
      r_frame_valid <= 1'b0;
      r_state       <= BYTE0;
      r_byte        <= '0;
      r_pix_cnt     <= '0;
      r_vsync_o     <= 1'b0;
      r_href_o      <= 1'b0;
      r_clken       <= 1'b0;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_byte_err    <= 1'b0;
      r_line_err    <= 1'b0;
    end else begin
      r_vsync_d <= cmos_vsync;
      r_href_d  <= cmos_href;

      if (w_vsync_rise) begin
        if (r_frame_cnt == SKIP_TGT) begin
          r_frame_valid <= 1'b1;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end

      r_vsync_o <= cmos_vsync & w_valid_next;
      r_href_o  <= cmos_href & w_valid_next;
      r_clken   <= w_pix_done & w_valid_next;

      if (w_href_rise) begin
        r_pix_cnt <= '0;
        if (w_strobe) begin
          r_byte  <= cmos_data;
          r_state <= BYTE1;
        end else begin
          r_state <= BYTE0;
        end
      end else if (w_href_fall) begin
        r_state <= BYTE0;
        if (r_frame_valid) begin
          if (r_state == BYTE1) r_byte_err <= 1'b1;
          if (r_pix_cnt != H_TGT) r_line_err <= 1'b1;
        end
      end else if (w_strobe) begin
        if (r_state == BYTE0) begin
          r_byte  <= cmos_data;
          r_state <= BYTE1;
        end else begin
          r_state <= BYTE0;
          if (r_pix_cnt != PIX_MAX) r_pix_cnt <= r_pix_cnt + 1'b1;
        end
      end

      if (w_pix_done & w_valid_next) begin
        r_red   <= w_red;
        r_green <= w_green;
        r_blue  <= w_blue;
      end
    end
  end

  assign post_frame_vsync = r_vsync_o;
  assign post_frame_href  = r_href_o;
  assign post_frame_clken = r_clken;
  assign post_img_red     = r_red;
  assign post_img_green   = r_green;
  assign post_img_blue    = r_blue;
  assign frame_valid      = r_frame_valid;
  assign byte_err         = r_byte_err;
  assign line_err         = r_line_err;

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// tb/tb_cmos_rgb565_capture.sv - self-checking bench for cmos_rgb565_capture
module tb_cmos_rgb565_capture;

  localparam int FS = 2;
  localparam int HP = 4;

  typedef struct {
    int          cyc;
    logic [23:0] rgb;
  } px_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmos_vsync = 1'b0;
  logic       cmos_href = 1'b0;
  logic       cmos_de = 1'b0;
  logic [7:0] cmos_data = 8'h00;

  logic       m_vsync, m_href, m_clken, m_fv, m_berr, m_lerr;
  logic [7:0] m_r, m_g, m_b;
  logic       l_vsync, l_href, l_clken, l_fv, l_berr, l_lerr;
  logic [7:0] l_r, l_g, l_b;

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  rises = 0;
  logic eb_m = 0, el_m = 0, eb_l = 0, el_l = 0;
  px_t exp_m[$];
  px_t exp_l[$];
  logic s_rst = 1'b1, s_vsync = 1'b0, s_href = 1'b0;

  cmos_rgb565_capture #(.FRAME_SKIP(FS), .H_PIXELS(HP), .HI_BYTE_FIRST(1)) u_dut (
    .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_de(cmos_de), .cmos_data(cmos_data),
    .post_frame_vsync(m_vsync), .post_frame_href(m_href), .post_frame_clken(m_clken),
    .post_img_red(m_r), .post_img_green(m_g), .post_img_blue(m_b),
    .frame_valid(m_fv), .byte_err(m_berr), .line_err(m_lerr)
  );

  cmos_rgb565_capture #(.FRAME_SKIP(0), .H_PIXELS(HP), .HI_BYTE_FIRST(0)) u_lo (
    .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_de(cmos_de), .cmos_data(cmos_data),
    .post_frame_vsync(l_vsync), .post_frame_href(l_href), .post_frame_clken(l_clken),
    .post_img_red(l_r), .post_img_green(l_g), .post_img_blue(l_b),
    .frame_valid(l_fv), .byte_err(l_berr), .line_err(l_lerr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    s_rst   <= rst;
    s_vsync <= cmos_vsync;
    s_href  <= cmos_href;
  end

  function automatic logic [23:0] expand(input int w);
    int r5, g6, b5;
    r5 = w / 2048;
    g6 = (w / 32) % 64;
    b5 = w % 32;
    return 24'((r5 * 8 + r5 / 4) * 65536 + (g6 * 4 + g6 / 16) * 256 + (b5 * 8 + b5 / 4));
  endfunction

  // Pixel and timing scoreboard: every clken must match the head of the expected queue.
  always @(negedge clk) begin
    if (!s_rst) begin
      n_checks++;
      if (m_vsync !== (s_vsync && rises >= FS + 1) || m_href !== (s_href && rises >= FS + 1)) begin
        n_fail++;
        $display("FAIL gate cyc=%0d vsync/href got %b%b expected %b%b", cyc, m_vsync, m_href,
                 s_vsync && rises >= FS + 1, s_href && rises >= FS + 1);
      end
      if (m_clken) begin
        n_checks++;
        if (exp_m.size() == 0) begin
          n_fail++;
          $display("FAIL pix_main cyc=%0d got clken rgb=%h expected no clken", cyc, {m_r, m_g, m_b});
        end else begin
          px_t e;
          e = exp_m.pop_front();
          if (e.cyc != cyc || {m_r, m_g, m_b} !== e.rgb) begin
            n_fail++;
            $display("FAIL pix_main got cyc=%0d rgb=%h expected cyc=%0d rgb=%h", cyc, {m_r, m_g, m_b}, e.cyc, e.rgb);
          end
        end
      end else if (exp_m.size() > 0 && exp_m[0].cyc <= cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL pix_main missing clken at cyc=%0d got 0 expected rgb=%h", exp_m[0].cyc, exp_m[0].rgb);
        void'(exp_m.pop_front());
      end
      if (l_clken) begin
        n_checks++;
        if (exp_l.size() == 0) begin
          n_fail++;
          $display("FAIL pix_lo cyc=%0d got clken rgb=%h expected no clken", cyc, {l_r, l_g, l_b});
        end else begin
          px_t e;
          e = exp_l.pop_front();
          if (e.cyc != cyc || {l_r, l_g, l_b} !== e.rgb) begin
            n_fail++;
            $display("FAIL pix_lo got cyc=%0d rgb=%h expected cyc=%0d rgb=%h", cyc, {l_r, l_g, l_b}, e.cyc, e.rgb);
          end
        end
      end else if (exp_l.size() > 0 && exp_l[0].cyc <= cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL pix_lo missing clken at cyc=%0d got 0 expected rgb=%h", exp_l[0].cyc, exp_l[0].rgb);
        void'(exp_l.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_vsync();
    cmos_vsync = 1'b1;
    rises++;
    tick();
    tick();
    cmos_vsync = 1'b0;
    tick();
    tick();
  endtask

  // mode 0: de every cycle, 1: every other cycle, 2: random
  task automatic send_line(input logic [7:0] b[$], input int mode);
    int idx = 0;
    int k = 0;
    int w;
    px_t p;
    cmos_href = 1'b1;
    while (idx < b.size() && k < 1000) begin
      cmos_de = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
      if (cmos_de) begin
        cmos_data = b[idx];
        if (idx % 2 == 1) begin
          p.cyc = cyc + 1;
          w = b[idx - 1] * 256 + b[idx];
          p.rgb = expand(w);
          if (rises >= FS + 1) exp_m.push_back(p);
          w = b[idx] * 256 + b[idx - 1];
          p.rgb = expand(w);
          if (rises >= 1) exp_l.push_back(p);
        end
        idx++;
      end else begin
        cmos_data = 8'($urandom_range(0, 255));
      end
      k++;
      tick();
    end
    cmos_href = 1'b0;
    cmos_de = 1'b0;
    if (rises >= FS + 1 && (b.size() % 2) == 1) eb_m = 1'b1;
    if (rises >= FS + 1 && (b.size() / 2) != HP) el_m = 1'b1;
    if (rises >= 1 && (b.size() % 2) == 1) eb_l = 1'b1;
    if (rises >= 1 && (b.size() / 2) != HP) el_l = 1'b1;
    repeat (3) tick();
  endtask

  task automatic random_line(input int nbytes, input int mode);
    logic [7:0] q[$];
    for (int i = 0; i < nbytes; i++) q.push_back(8'($urandom_range(0, 255)));
    send_line(q, mode);
  endtask

  task automatic check_flags(input string name);
    n_checks++;
    if ({m_berr, m_lerr, l_berr, l_lerr} !== {eb_m, el_m, eb_l, el_l}) begin
      n_fail++;
      $display("FAIL %s err flags got %b expected %b", name, {m_berr, m_lerr, l_berr, l_lerr}, {eb_m, el_m, eb_l, el_l});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({m_vsync, m_href, m_clken, m_r, m_g, m_b, m_fv, m_berr, m_lerr} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_main got %h expected 0", {m_vsync, m_href, m_clken, m_r, m_g, m_b, m_fv, m_berr, m_lerr});
    end
    n_checks++;
    if ({l_vsync, l_href, l_clken, l_r, l_g, l_b, l_fv, l_berr, l_lerr} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_lo got %h expected 0", {l_vsync, l_href, l_clken, l_r, l_g, l_b, l_fv, l_berr, l_lerr});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_skip_frames();
    for (int f = 0; f < FS; f++) begin
      do_vsync();
      random_line(8, 0);
      random_line(8, 2);
      n_checks++;
      if (m_fv !== 1'b0 || l_fv !== 1'b1) begin
        n_fail++;
        $display("FAIL skip_frame%0d frame_valid got main=%b lo=%b expected main=0 lo=1", f, m_fv, l_fv);
      end
    end
    check_flags("skip_frames");
  endtask

  task automatic test_frame_enable();
    logic [7:0] q[$];
    do_vsync();
    n_checks++;
    if (m_fv !== 1'b1) begin
      n_fail++;
      $display("FAIL enable frame_valid got %b expected 1", m_fv);
    end
    q = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    send_line(q, 0);
    n_checks++;
    if ({m_r, m_g, m_b} !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL enable_last_rgb got %h expected ffffff", {m_r, m_g, m_b});
    end
    q = '{8'hE0, 8'h07, 8'h1F, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hF8};
    send_line(q, 1);
    n_checks++;
    if ({l_r, l_g, l_b} !== 24'hFF0000) begin
      n_fail++;
      $display("FAIL lo_byte_order rgb got %h expected ff0000", {l_r, l_g, l_b});
    end
    check_flags("enable");
  endtask

  task automatic test_random_lines();
    for (int i = 0; i < 6; i++) random_line(8, 1 + (i % 2));
    check_flags("random_lines");
  endtask

  task automatic test_odd_line();
    random_line(7, 0);
    check_flags("odd_line");
    n_checks++;
    if (m_berr !== 1'b1 || m_lerr !== 1'b1) begin
      n_fail++;
      $display("FAIL odd_line main byte_err=%b line_err=%b expected 1 1", m_berr, m_lerr);
    end
    random_line(8, 2);
    check_flags("after_odd");
  endtask

  task automatic test_mid_reset();
    px_t p;
    cmos_href = 1'b1;
    cmos_de = 1'b1;
    cmos_data = 8'h07;
    tick();
    cmos_data = 8'hE0;
    p.cyc = cyc + 1;
    p.rgb = 24'h00FF00;
    exp_m.push_back(p);
    p.rgb = expand(16'hE007);
    exp_l.push_back(p);
    tick();
    cmos_de = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({m_vsync, m_href, m_clken, m_r, m_g, m_b, m_fv, m_berr, m_lerr} !== 33'd0) begin
      n_fail++;
      $display("FAIL mid_reset_main got %h expected 0", {m_vsync, m_href, m_clken, m_r, m_g, m_b, m_fv, m_berr, m_lerr});
    end
    n_checks++;
    if ({l_clken, l_r, l_g, l_b, l_fv, l_berr, l_lerr} !== 30'd0) begin
      n_fail++;
      $display("FAIL mid_reset_lo got %h expected 0", {l_clken, l_r, l_g, l_b, l_fv, l_berr, l_lerr});
    end
    rises = 0;
    {eb_m, el_m, eb_l, el_l} = 4'b0000;
    cmos_href = 1'b0;
    repeat (3) tick();
    for (int f = 0; f < FS; f++) begin
      do_vsync();
      random_line(8, 2);
    end
    n_checks++;
    if (m_fv !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_skip frame_valid got %b expected 0", m_fv);
    end
    do_vsync();
    random_line(8, 0);
    n_checks++;
    if (m_fv !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_resume frame_valid got %b expected 1", m_fv);
    end
    check_flags("mid_reset");
  endtask

  initial begin
    test_reset();
    test_skip_frames();
    test_frame_enable();
    test_random_lines();
    test_odd_line();
    test_mid_reset();
    repeat (4) tick();
    n_checks++;
    if (exp_m.size() != 0 || exp_l.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending pixels got main=%0d lo=%0d expected 0 0", exp_m.size(), exp_l.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
